parity_checker: RTL and testbench

PARITY_CHECKER -- requirements
Module: parity_checker

---
 rtl/parity_checker.sv | 128 ++++++++++++
 tb/tb_parity_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/parity_checker.sv
// Serial frame receiver: WIDTH data bits LSB first plus one parity bit; checks even/odd parity.
// Latency WIDTH+3 cycles counting the start cycle; bit_valid=0 stalls the frame, there is no backpressure output.
module parity_checker #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 odd_mode,
  input  logic                 ser_in,
  input  logic                 bit_valid,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  output logic                 parity_ok,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic                 run_q, run_d;
  logic                 odd_q, odd_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
  logic                 sticky_q, sticky_d;
  logic                 frame_err;
  logic                 fail_evt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    run_d     = run_q;
    odd_d     = odd_q;
    data_d    = data_q;
    ok_d      = ok_q;
    err_d     = err_q;
    frame_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = '0;
          run_d   = 1'b0;
          odd_d   = odd_mode;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          sh_d  = sh_q | (WIDTH'(ser_in) << cnt_q);
          run_d = run_q ^ ser_in;
          if (cnt_q == LAST_BIT) state_d = PAR;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      PAR: begin
        if (bit_valid) begin
          // odd mode expects the XOR of all WIDTH+1 bits to be 1
          frame_err = run_q ^ ser_in ^ odd_q;
          data_d    = sh_q;
          ok_d      = ~frame_err;
          err_d     = frame_err;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error bookkeeping acts on the out_valid cycle; clear is applied before the count.
  assign fail_evt = (state_q == DONE) && err_q;

  always_comb begin
    ecnt_d = clr_err ? '0 : ecnt_q;
    if (fail_evt && (ecnt_d != '1)) ecnt_d = ecnt_d + ERR_CNT_W'(1);
    sticky_d = (clr_err ? 1'b0 : sticky_q) | fail_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      run_q    <= 1'b0;
      odd_q    <= 1'b0;
      data_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      run_q    <= run_d;
      odd_q    <= odd_d;
      data_q   <= data_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign data_out   = data_q;
  assign out_valid  = (state_q == DONE);
  assign parity_ok  = ok_q;
  assign parity_err = err_q;
  assign busy       = (state_q != IDLE);
  assign err_count  = ecnt_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_checker.sv
// Directed bench for parity_checker (WIDTH=8, ERR_CNT_W=8); inputs driven and outputs sampled on the falling edge.
module tb_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       odd_mode = 1'b0;
  logic       ser_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic       parity_ok;
  logic       parity_err;
  logic       busy;
  logic [7:0] err_count;
  logic       err_sticky;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  parity_checker #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .odd_mode  (odd_mode),
    .ser_in    (ser_in),
    .bit_valid (bit_valid),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .out_valid (out_valid),
    .parity_ok (parity_ok),
    .parity_err(parity_err),
    .busy      (busy),
    .err_count (err_count),
    .err_sticky(err_sticky)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns on the falling edge where out_valid should be high. lat counts the
  // start cycle as cycle 1; a frame that never completes shows up as lat=41.
  task automatic run_frame(input logic [7:0] d, input logic p, input logic odd,
                           input bit toggle, input bit spam, output int lat);
    int k;
    int idx;
    bit ph;
    k = 0; idx = 0; ph = 0;
    start = 1'b1; odd_mode = odd; bit_valid = 1'b0;
    @(negedge clk); k = 1;
    start = 1'b0;
    odd_mode = ~odd;
    check_vec("busy_in_frame", busy, 1);
    while (idx < 9) begin
      if (toggle && ph) begin
        bit_valid = 1'b0;
        ser_in    = ~ser_in;
      end else begin
        bit_valid = 1'b1;
        ser_in    = (idx < 8) ? d[idx] : p;
        idx++;
      end
      start = spam;
      ph = ~ph;
      @(negedge clk); k++;
    end
    bit_valid = 1'b0;
    start = 1'b0;
    while (!out_valid && k < 40) begin
      @(negedge clk); k++;
    end
    lat = k + 1;
  endtask

  task automatic post_check(input logic [7:0] exp_cnt, input logic exp_sticky);
    @(negedge clk);
    check_vec("ov_one_cycle", out_valid, 0);
    check_vec("err_count", err_count, exp_cnt);
    check_vec("err_sticky", err_sticky, exp_sticky);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    #1;
    check_vec("rst_data", data_out, 0);
    check_vec("rst_ov", out_valid, 0);
    check_vec("rst_ok", parity_ok, 0);
    check_vec("rst_err", parity_err, 0);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_cnt", err_count, 0);
    check_vec("rst_sticky", err_sticky, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 0xA5 has four ones: even parity bit 0 passes
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check_vec("a5_even_lat", lat, 11);
    check_vec("a5_even_data", data_out, 8'hA5);
    check_vec("a5_even_ok", parity_ok, 1);
    check_vec("a5_even_err", parity_err, 0);
    post_check(8'd0, 1'b0);

    run_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    check_vec("a5_odd_p0_err", parity_err, 1);
    check_vec("a5_odd_p0_ok", parity_ok, 0);
    post_check(8'd1, 1'b1);

    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    check_vec("a5_odd_p1_ok", parity_ok, 1);
    check_vec("a5_odd_p1_err", parity_err, 0);
    post_check(8'd1, 1'b1);

    // 0x07: three ones, even p=0 fails; 8 stall cycles stretch latency to 19
    run_frame(8'h07, 1'b0, 1'b0, 1'b1, 1'b1, lat);
    check_vec("07_toggle_lat", lat, 19);
    check_vec("07_toggle_data", data_out, 8'h07);
    check_vec("07_toggle_err", parity_err, 1);
    check_vec("07_toggle_ok", parity_ok, 0);
    post_check(8'd2, 1'b1);

    // start asserted during DONE must not launch a frame
    run_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check_vec("00_ok", parity_ok, 1);
    start = 1'b1;
    post_check(8'd2, 1'b1);
    check_vec("done_start_idle", busy, 0);
    start = 1'b0;
    @(negedge clk);
    check_vec("done_start_noqueue", busy, 0);

    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_vec("clr_cnt", err_count, 0);
    check_vec("clr_sticky", err_sticky, 0);
    check_vec("clr_keeps_data", data_out, 8'h00);
    check_vec("clr_keeps_ok", parity_ok, 1);

    for (int i = 0; i < 255; i++) begin
      run_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      post_check(8'(i + 1), 1'b1);
    end
    check_vec("sat_255", err_count, 255);
    run_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    post_check(8'd255, 1'b1);

    run_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    clr_err = 1'b1;
    post_check(8'd1, 1'b1);
    clr_err = 1'b0;
    check_vec("clr_fail_data", data_out, 8'h01);
    check_vec("clr_fail_err", parity_err, 1);

    // reset after four data bits of 0xFF
    start = 1'b1; odd_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; ser_in = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_busy", busy, 0);
    check_vec("mid_rst_ov", out_valid, 0);
    check_vec("mid_rst_data", data_out, 0);
    check_vec("mid_rst_err", parity_err, 0);
    check_vec("mid_rst_cnt", err_count, 0);
    check_vec("mid_rst_sticky", err_sticky, 0);
    bit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_vec("post_rst_ov", out_valid, 0);
    end
    check_vec("post_rst_busy", busy, 0);

    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check_vec("3c_lat", lat, 11);
    check_vec("3c_data", data_out, 8'h3C);
    check_vec("3c_ok", parity_ok, 1);
    post_check(8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
